// File: rtl/ocra_dac_bank_model_pkg.sv
// Shared definitions for the AD5781-style DAC bank model: register addresses,
// control-register bit positions and the control-register reset value.
package ocra_dac_bank_model_pkg;

  typedef enum logic [2:0] {
    AddrNop     = 3'd0,
    AddrDac     = 3'd1,
    AddrCtrl    = 3'd2,
    AddrClrcode = 3'd3,
    AddrSwctrl  = 3'd4
  } dac_addr_e;

  localparam int unsigned CTRL_BITS   = 6;
  localparam logic [CTRL_BITS-1:0] CTRL_RST = 6'b001110;
  localparam int unsigned CTRL_OPGND  = 2;
  localparam int unsigned CTRL_DACTRI = 3;
  localparam int unsigned CTRL_BIN2SC = 4;

  localparam int unsigned SW_LDAC  = 0;
  localparam int unsigned SW_CLR   = 1;
  localparam int unsigned SW_RESET = 2;

  localparam int unsigned PAYLOAD_MSB = 19;

  // Output is driven only when neither ground-clamp nor tristate is requested.
  function automatic logic dac_enabled(input logic [CTRL_BITS-1:0] ctrl);
    return ~ctrl[CTRL_OPGND] & ~ctrl[CTRL_DACTRI];
  endfunction

endpackage

// File: rtl/ocra_dac_bank_model_channel.sv
// One DAC channel: serial deserialiser, frame decode, input/clearcode/control
// registers and the output register with its update and frame-error pulses.
module ocra_dac_bank_model_channel
  import ocra_dac_bank_model_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned DATA_BITS  = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 syncn,
  input  logic                 ldacn,
  input  logic                 sdo,
  output logic [DATA_BITS-1:0] dac_out,
  output logic                 dac_en,
  output logic                 frame_err,
  output logic                 upd_pulse
);

  localparam int unsigned CntW = $clog2(FRAME_BITS + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(FRAME_BITS + 1);

  logic [FRAME_BITS-1:0] shift_q;
  logic [CntW-1:0]       cnt_q;
  logic                  active_q, ldacn_q;
  logic [DATA_BITS-1:0]  in_q, in_d, clr_q, clr_d, out_q, code;
  logic [CTRL_BITS-1:0]  ctrl_q, ctrl_d;
  logic                  commit, wr, dac_wr, sw_rst, sw_clr, sw_ldac, load, upd;
  logic                  ferr_q, upd_q;
  dac_addr_e             addr;

  function automatic logic [DATA_BITS-1:0] to_out(input logic [DATA_BITS-1:0] c,
                                                  input logic bin2sc);
    return bin2sc ? c : {~c[DATA_BITS-1], c[DATA_BITS-2:0]};
  endfunction

  always_comb begin
    commit  = syncn & active_q;
    wr      = commit & (cnt_q == CntFull) & ~shift_q[FRAME_BITS-1];
    addr    = dac_addr_e'(shift_q[FRAME_BITS-2 -: 3]);
    code    = shift_q[PAYLOAD_MSB -: DATA_BITS];
    in_d    = in_q;
    clr_d   = clr_q;
    ctrl_d  = ctrl_q;
    dac_wr  = 1'b0;
    sw_rst  = 1'b0;
    sw_clr  = 1'b0;
    sw_ldac = 1'b0;
    if (wr) begin
      case (addr)
        AddrDac: begin
          in_d   = code;
          dac_wr = 1'b1;
        end
        AddrCtrl:    ctrl_d = shift_q[CTRL_BITS-1:0];
        AddrClrcode: clr_d  = code;
        AddrSwctrl: begin
          // RESET beats CLR beats LDAC within one word.
          sw_rst  = shift_q[SW_RESET];
          sw_clr  = ~shift_q[SW_RESET] & shift_q[SW_CLR];
          sw_ldac = ~shift_q[SW_RESET] & ~shift_q[SW_CLR] & shift_q[SW_LDAC];
          if (sw_clr) in_d = clr_q;
        end
        default: ;
      endcase
    end
    load = sw_clr | sw_ldac | ~ldacn;
    // A held-low LDAC reloads silently; only its first edge or a code write pulses.
    upd  = sw_clr | sw_ldac | (~ldacn & (ldacn_q | dac_wr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      ldacn_q  <= 1'b1;
      in_q     <= '0;
      clr_q    <= '0;
      out_q    <= '0;
      ctrl_q   <= CTRL_RST;
      ferr_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      ldacn_q <= ldacn;
      if (!syncn) begin
        shift_q  <= {shift_q[FRAME_BITS-2:0], sdo};
        active_q <= 1'b1;
        if (cnt_q != CntSat) cnt_q <= cnt_q + 1'b1;
      end else begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end
      ferr_q <= commit & (cnt_q != CntFull);
      if (sw_rst) begin
        in_q   <= '0;
        clr_q  <= '0;
        out_q  <= '0;
        ctrl_q <= CTRL_RST;
        upd_q  <= 1'b0;
      end else begin
        in_q   <= in_d;
        clr_q  <= clr_d;
        ctrl_q <= ctrl_d;
        upd_q  <= upd;
        if (load) out_q <= to_out(in_d, ctrl_q[CTRL_BIN2SC]);
      end
    end
  end

  assign dac_out   = out_q;
  assign dac_en    = dac_enabled(ctrl_q);
  assign frame_err = ferr_q;
  assign upd_pulse = upd_q;

endmodule

// File: rtl/ocra_dac_bank_model.sv
// N-channel DAC bank: shared SYNC/LDAC/reset broadcast to per-channel models,
// outputs packed with channel 0 in the least significant bits.
module ocra_dac_bank_model
  import ocra_dac_bank_model_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned DATA_BITS  = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      syncn,
  input  logic                      ldacn,
  input  logic [N_CH-1:0]           sdo,
  output logic [N_CH*DATA_BITS-1:0] dac_out,
  output logic [N_CH-1:0]           dac_en,
  output logic [N_CH-1:0]           frame_err,
  output logic [N_CH-1:0]           upd_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ocra_dac_bank_model_channel #(
      .FRAME_BITS(FRAME_BITS),
      .DATA_BITS (DATA_BITS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .syncn    (syncn),
      .ldacn    (ldacn),
      .sdo      (sdo[i]),
      .dac_out  (dac_out[i*DATA_BITS +: DATA_BITS]),
      .dac_en   (dac_en[i]),
      .frame_err(frame_err[i]),
      .upd_pulse(upd_pulse[i])
    );
  end

endmodule
